// File: rtl/sam_pkg.sv
// sam_pkg: shared definitions for the sam_rv32i pipeline interlock controller.
//   - opcode / funct3 constants of the reduced instruction set
//   - NOP_IR, the instruction used to squash pipeline registers
//   - FSM state encoding and in-flight table entry type
//   - instruction field extract helpers
package sam_pkg;

  localparam logic [6:0] AR_TYPE = 7'd0;
  localparam logic [6:0] M_TYPE  = 7'd1;
  localparam logic [6:0] BR_TYPE = 7'd2;
  localparam logic [6:0] SH_TYPE = 7'd3;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] SW  = 3'd1;
  localparam logic [2:0] BEQ = 3'd0;
  localparam logic [2:0] BNE = 3'd1;

  // Opcode 7'h7F matches no instruction type: neither writer nor reader.
  localparam logic [31:0] NOP_IR = 32'h0000_007F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  // One slot of the in-flight destination table.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } inflight_t;

  function automatic logic [6:0] ir_opcode(input logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [4:0] ir_rd(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [4:0] ir_rs1(input logic [31:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [4:0] ir_rs2(input logic [31:0] ir);
    return ir[24:20];
  endfunction

  function automatic logic [2:0] ir_f3(input logic [31:0] ir);
    return ir[14:12];
  endfunction

  function automatic logic [6:0] ir_f7(input logic [31:0] ir);
    return ir[31:25];
  endfunction

endpackage

// File: rtl/sam_dec_deps.sv
// sam_dec_deps: combinational register-dependency decoder.
// Ports:
//   ir        in   instruction word
//   is_writer out  instruction writes a nonzero rd
//   rd        out  destination register index
//   rs1/rs2/rs3 out source register indices, each with a *_use flag
//                  (rs3 is the store-data register held in ir[11:7] of SW)
module sam_dec_deps
  import sam_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_writer,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic        rs1_use,
  output logic [4:0]  rs2,
  output logic        rs2_use,
  output logic [4:0]  rs3,
  output logic        rs3_use
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    opc = ir_opcode(ir);
    f3  = ir_f3(ir);
    f7  = ir_f7(ir);

    rd  = ir_rd(ir);
    rs1 = ir_rs1(ir);
    rs2 = ir_rs2(ir);
    rs3 = ir_rd(ir);

    is_writer = 1'b0;
    rs1_use   = 1'b0;
    rs2_use   = 1'b0;
    rs3_use   = 1'b0;

    unique case (opc)
      AR_TYPE: begin
        is_writer = 1'b1;
        rs1_use   = 1'b1;
        rs2_use   = (f7 == 7'd1);
      end
      M_TYPE: begin
        is_writer = (f3 == LW);
        rs1_use   = 1'b1;
        rs3_use   = (f3 == SW);
      end
      SH_TYPE: begin
        is_writer = 1'b1;
        rs1_use   = 1'b1;
      end
      // BR compares field indices, not register contents.
      default: ;
    endcase

    // r0 is hardwired; a write to it never creates a dependency.
    if (rd == 5'd0) is_writer = 1'b0;
  end

endmodule

// File: rtl/sam_pipe_ctrl.sv
// sam_pipe_ctrl: interlock and sequencing controller for the 5-stage
// sam_rv32i pipeline (no forwarding).
// Ports:
//   clk         pipeline clock
//   RN          synchronous active-high reset
//   id_ir       instruction in IF/ID;  id_valid: IF/ID holds a real instruction
//   br_taken    one-cycle branch-taken pulse from EX
//   mem_busy    data memory not ready this cycle
//   hold_if     hold NPC and IF/ID
//   bubble_ex   load NOP_IR into ID/EX
//   flush_ifid  replace IF/ID with NOP_IR
//   freeze      all pipeline registers hold
//   state       FSM state (RUN/STALL/FLUSH/FREEZE)
//   stall_cnt, flush_cnt, freeze_cnt  saturating event counters
// Handshake: none; every output is a same-cycle combinational command that
// the datapath applies at the next clk edge.
module sam_pipe_ctrl
  import sam_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             RN,
  input  logic [31:0]      id_ir,
  input  logic             id_valid,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             hold_if,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  inflight_t         ex_q, mem_q, wb_q;

  logic       is_writer, rs1_use, rs2_use, rs3_use;
  logic [4:0] rd, rs1, rs2, rs3;
  logic       hazard, issue;

  sam_dec_deps u_dec (
    .ir        (id_ir),
    .is_writer (is_writer),
    .rd        (rd),
    .rs1       (rs1),
    .rs1_use   (rs1_use),
    .rs2       (rs2),
    .rs2_use   (rs2_use),
    .rs3       (rs3),
    .rs3_use   (rs3_use)
  );

  // WB is included: the register file write and the ID read share one edge,
  // so ID would still see the old value.
  function automatic logic pending(input logic use_f, input logic [4:0] r,
                                   input inflight_t e0, input inflight_t e1,
                                   input inflight_t e2);
    return use_f && (r != 5'd0) &&
           ((e0.v && e0.rd == r) || (e1.v && e1.rd == r) || (e2.v && e2.rd == r));
  endfunction

  always_comb begin
    hazard = id_valid && (pending(rs1_use, rs1, ex_q, mem_q, wb_q) ||
                          pending(rs2_use, rs2, ex_q, mem_q, wb_q) ||
                          pending(rs3_use, rs3, ex_q, mem_q, wb_q));
  end

  // Outputs: RN > freeze > flush > hazard.
  always_comb begin
    hold_if    = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    freeze     = 1'b0;
    if (!RN) begin
      if (mem_busy) begin
        freeze = 1'b1;
      end else if (br_taken || state_q == ST_FLUSH) begin
        flush_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end else if (hazard) begin
        hold_if   = 1'b1;
        bubble_ex = 1'b1;
      end
    end
    issue = id_valid && !RN && !freeze && !bubble_ex;
  end

  // The br_taken cycle is the first squash cycle; FLUSH then lasts fcnt more
  // cycles, giving FLUSH_CYCLES squashed cycles in total. A FREEZE cycle with
  // mem_busy already low behaves exactly like RUN.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (mem_busy) begin
      state_d = ST_FREEZE;
    end else if (br_taken) begin
      state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
    end else if (state_q == ST_FLUSH) begin
      if (fcnt_q <= FCNT_W'(1)) begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FCNT_W'(1);
      end
    end else begin
      state_d = hazard ? ST_STALL : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // In-flight destination table; holds still while frozen.
  always_ff @(posedge clk) begin
    if (RN) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      ex_q  <= '{v: issue && is_writer, rd: rd};
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (hold_if && stall_cnt != '1)     stall_cnt  <= stall_cnt + CNT_W'(1);
      if (flush_ifid && flush_cnt != '1)  flush_cnt  <= flush_cnt + CNT_W'(1);
      if (freeze && freeze_cnt != '1)     freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule
